// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Define IF_STAGE_PERF_EN to add the fetch_count / bubble_count performance counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_data,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid
`ifdef IF_STAGE_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    // Word alignment is enforced on every PC source, including the reset value.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        redirect;
    logic        bubble;
    logic        load;

    always_comb begin
        pc_plus4 = pc + 32'd4;
        redirect = branch_taken | jump;
        bubble   = redirect | flush;
        // Redirect beats stall; a non-redirect flush still honours stall for the PC.
        load     = !bubble && !stall;
        if (branch_taken)
            pc_next = {branch_target[31:2], 2'b00};
        else if (jump)
            pc_next = {jump_target[31:2], 2'b00};
        else if (stall)
            pc_next = pc;
        else
            pc_next = pc_plus4;
    end

    assign inst_addr = pc;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC_ALIGNED;
            if_id_inst     <= NOP_INST;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
        end else begin
            pc <= pc_next;
            if (bubble) begin
                if_id_inst     <= NOP_INST;
                if_id_pc_plus4 <= 32'd0;
                if_id_valid    <= 1'b0;
            end else if (load) begin
                if_id_inst     <= inst_data;
                if_id_pc_plus4 <= pc_plus4;
                if_id_valid    <= 1'b1;
            end
        end
    end

`ifdef IF_STAGE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count  <= 32'd0;
            bubble_count <= 32'd0;
        end else begin
            if (load)
                fetch_count <= fetch_count + 32'd1;
            if (bubble)
                bubble_count <= bubble_count + 32'd1;
        end
    end
`endif

endmodule
